// File: rtl/regbank_wr_16_if.sv
// Write-request channel of the 16-entry register bank.
// Valid/ready: a request transfers on a rising edge where wr_valid_i & wr_ready_o.
// While wr_valid_i is high and the request has not transferred, the master keeps
// wr_addr_i, wr_data_i and wr_be_i stable.
interface regbank_wr_16_if #(
  parameter int W = 32
);
  logic           wr_valid_i;
  logic           wr_ready_o;
  logic [3:0]     wr_addr_i;
  logic [W-1:0]   wr_data_i;
  logic [W/8-1:0] wr_be_i;

  modport master (
    output wr_valid_i,
    output wr_addr_i,
    output wr_data_i,
    output wr_be_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  wr_be_i,
    output wr_ready_o
  );
endinterface

// File: rtl/regbank_wr_16.sv
// Write side of a 16-entry register bank: bytewise merged writes, per-entry dirty
// bits and a 16-cycle sequential clear sweep.
module regbank_wr_16 #(
  parameter int W       = 32,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  regbank_wr_16_if.slave  wr,
  input  logic            clr_req_i,
  output logic            clr_busy_o,
  output logic [16*W-1:0] regs_o,
  output logic [15:0]     dirty_o,
  output logic            dbg_state_o,
  output logic [3:0]      dbg_idx_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [W-1:0]   regs_q [16];
  logic [W-1:0]   regs_d [16];
  logic [15:0]    dirty_q, dirty_d;
  logic           wr_ready;
  logic           clr_busy;
  logic           r0_drop;

  assign r0_drop = ZERO_R0 && (wr.wr_addr_i == 4'd0);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    regs_d   = regs_q;
    dirty_d  = dirty_q;
    wr_ready = 1'b0;
    clr_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A clear request blocks the write channel in the same cycle it is seen.
        wr_ready = ~clr_req_i;
        if (clr_req_i) begin
          state_d = S_CLEAR;
          idx_d   = 4'd0;
        end else if (wr.wr_valid_i && !r0_drop) begin
          for (int k = 0; k < W/8; k++) begin
            if (wr.wr_be_i[k]) begin
              regs_d[wr.wr_addr_i][8*k +: 8] = wr.wr_data_i[8*k +: 8];
            end
          end
          if (|wr.wr_be_i) begin
            dirty_d[wr.wr_addr_i] = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        clr_busy       = 1'b1;
        regs_d[idx_q]  = '0;
        dirty_d[idx_q] = 1'b0;
        if (idx_q == 4'd15) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      dirty_q <= '0;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign regs_o[g*W +: W] = regs_q[g];
  end

  assign wr.wr_ready_o = wr_ready;
  assign clr_busy_o    = clr_busy;
  assign dirty_o       = dirty_q;
  assign dbg_state_o   = state_q;
  assign dbg_idx_o     = idx_q;

endmodule

// File: tb/tb_regbank_wr_16.sv
// Directed bench for regbank_wr_16: table of back-to-back writes with hand-computed
// results, then clear-sweep and reset-mid-sweep sequences.
module tb_regbank_wr_16;
  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            clr_req;
  logic            clr_busy;
  logic [16*W-1:0] regs;
  logic [15:0]     dirty;
  logic            dbg_state;
  logic [3:0]      dbg_idx;

  int checks = 0;
  int errors = 0;

  regbank_wr_16_if #(.W(W)) wr_if ();

  regbank_wr_16 #(.W(W), .ZERO_R0(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr         (wr_if),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .regs_o     (regs),
    .dirty_o    (dirty),
    .dbg_state_o(dbg_state),
    .dbg_idx_o  (dbg_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_entry;
    logic [15:0] exp_dirty;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [W-1:0] entry(input int i);
    return regs[i*W +: W];
  endfunction

  function automatic logic [W-1:0] fill_val(input int i);
    logic [W-1:0] v;
    v = (i == 0) ? '0 : 32'h01010101 * (i + 1);
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    wr_if.wr_valid_i = v;
    wr_if.wr_addr_i  = a;
    wr_if.wr_data_i  = d;
    wr_if.wr_be_i    = be;
  endtask

  initial begin
    vecs[0] = '{4'd5,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 16'h0020};
    vecs[1] = '{4'd5,  32'h11223344, 4'h5, 32'hDE22BE44, 16'h0020};
    vecs[2] = '{4'd0,  32'hFFFFFFFF, 4'hF, 32'h00000000, 16'h0020};
    vecs[3] = '{4'd3,  32'hCAFEF00D, 4'h0, 32'h00000000, 16'h0020};
    vecs[4] = '{4'd3,  32'hCAFEF00D, 4'h8, 32'hCA000000, 16'h0028};
    vecs[5] = '{4'd3,  32'h12345678, 4'h3, 32'hCA005678, 16'h0028};
    vecs[6] = '{4'd15, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 16'h8028};
    vecs[7] = '{4'd5,  32'h00000000, 4'h2, 32'hDE220044, 16'h8028};

    rst     = 1'b1;
    clr_req = 1'b0;
    drive_wr(1'b0, 4'd0, 32'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_regs", {63'd0, |regs}, 64'd0);
    check("reset_dirty", {48'd0, dirty}, 64'd0);
    rst = 1'b0;
    #1;
    check("reset_ready", {63'd0, wr_if.wr_ready_o}, 64'd1);
    check("reset_busy", {63'd0, clr_busy}, 64'd0);

    // back-to-back write table: valid stays high across consecutive edges
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      drive_wr(1'b1, vecs[v].addr, vecs[v].data, vecs[v].be);
      #1;
      check($sformatf("vec%0d_ready", v), {63'd0, wr_if.wr_ready_o}, 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_entry", v), {32'd0, entry(int'(vecs[v].addr))},
            {32'd0, vecs[v].exp_entry});
      check($sformatf("vec%0d_dirty", v), {48'd0, dirty}, {48'd0, vecs[v].exp_dirty});
      if (v == 0) begin
        for (int i = 0; i < 16; i++) begin
          if (i != 5) check($sformatf("vec0_other%0d", i), {32'd0, entry(i)}, 64'd0);
        end
      end
    end
    @(negedge clk);
    drive_wr(1'b0, 4'd0, 32'd0, 4'h0);

    // fill every entry, then clear with a concurrent write held pending
    for (int i = 0; i < 16; i++) begin
      drive_wr(1'b1, 4'(i), fill_val(i) | ((i == 0) ? 32'hFFFFFFFF : 32'd0), 4'hF);
      tick();
    end
    drive_wr(1'b0, 4'd0, 32'd0, 4'h0);
    for (int i = 0; i < 16; i++) check($sformatf("fill_entry%0d", i), {32'd0, entry(i)},
                                       {32'd0, fill_val(i)});
    check("fill_dirty", {48'd0, dirty}, 64'hFFFE);

    clr_req = 1'b1;
    drive_wr(1'b1, 4'd9, 32'h99887766, 4'hF);
    #1;
    check("clr_req_blocks_ready", {63'd0, wr_if.wr_ready_o}, 64'd0);
    tick();
    clr_req = 1'b0;
    check("clr_write_not_taken", {32'd0, entry(9)}, {32'd0, fill_val(9)});
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sweep%0d_busy", i), {63'd0, clr_busy}, 64'd1);
      check($sformatf("sweep%0d_ready", i), {63'd0, wr_if.wr_ready_o}, 64'd0);
      tick();
      check($sformatf("sweep%0d_entry", i), {32'd0, entry(i)}, 64'd0);
      check($sformatf("sweep%0d_dirtybit", i), {63'd0, dirty[i]}, 64'd0);
      if (i < 15) check($sformatf("sweep%0d_next_old", i), {32'd0, entry(i + 1)},
                        {32'd0, fill_val(i + 1)});
    end
    check("sweep_end_busy", {63'd0, clr_busy}, 64'd0);
    check("sweep_end_dirty", {48'd0, dirty}, 64'd0);
    check("sweep_end_ready", {63'd0, wr_if.wr_ready_o}, 64'd1);
    tick();
    drive_wr(1'b0, 4'd0, 32'd0, 4'h0);
    check("held_write_entry", {32'd0, entry(9)}, 64'h99887766);
    check("held_write_dirty", {48'd0, dirty}, 64'h0200);

    // reset in the middle of a sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    check("mid_sweep_idx", {60'd0, dbg_idx}, 64'd7);
    check("mid_sweep_state", {63'd0, dbg_state}, 64'd1);
    check("pre_reset_nonzero", {63'd0, |regs}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_regs", {63'd0, |regs}, 64'd0);
    check("async_reset_dirty", {48'd0, dirty}, 64'd0);
    check("async_reset_state", {63'd0, dbg_state}, 64'd0);
    check("async_reset_busy", {63'd0, clr_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_wr(1'b1, 4'd12, 32'h0C0C0C0C, 4'hF);
    #1;
    check("post_reset_ready", {63'd0, wr_if.wr_ready_o}, 64'd1);
    tick();
    drive_wr(1'b0, 4'd0, 32'd0, 4'h0);
    check("post_reset_entry12", {32'd0, entry(12)}, 64'h0C0C0C0C);
    check("post_reset_dirty", {48'd0, dirty}, 64'h1000);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regbank_wr_16.md
# regbank_wr_16

Write side of the 16-entry, W-bit register bank whose outputs feed the 16:1 read-select multiplexers. It accepts write requests over a valid/ready handshake, merges them bytewise into the addressed register and tracks a per-entry dirty bit. It also runs a sequential 16-cycle clear sweep on request. All 16 registers are exposed flat so any number of read muxes can sit downstream.

## Interface
- W, 32, register width in bits; must be a multiple of 8
- ZERO_R0, 1, when 1 entry 0 is hardwired to zero: writes to it are accepted, then discarded
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  write request can be accepted this cycle
- wr_addr_i  in  4  target entry index
- wr_data_i  in  W  write data
- wr_be_i  in  W/8  byte enables; bit k covers data bits [8k+7:8k]
- clr_req_i  in  1  start clear sweep (level, sampled in IDLE only)
- clr_busy_o  out  1  clear sweep in progress
- regs_o  out  16*W  flattened bank; entry i occupies bits [i*W+W-1:i*W]
- dirty_o  out  16  bit i set when entry i has been written since the last reset or clear

## Operation
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - all registers 0, dirty_o 0
  - state IDLE, sweep index 0
  - wr_ready_o 1 once rst_i deasserts, provided clr_req_i is low
  - clr_busy_o 0
- State machine with two states, IDLE and CLEAR.
- IDLE:
  - wr_ready_o = ~clr_req_i (combinational)
  - handshake: a write is accepted when wr_valid_i & wr_ready_o
  - on acceptance, for each k with wr_be_i[k]=1, byte k of entry wr_addr_i takes byte k of wr_data_i; other bytes are unchanged
  - dirty_o[wr_addr_i] is set if any wr_be_i bit is 1
  - if wr_be_i is 0, the write is accepted but is a no-op and dirty is unchanged
- ZERO_R0=1 and wr_addr_i=0: write accepted, entry 0 stays 0, dirty_o[0] stays 0.
- Clear request: clr_req_i=1 in IDLE → next edge: state CLEAR, index 0. Clear takes priority; any concurrent wr_valid_i is not accepted because wr_ready_o=0.
- CLEAR:
  - wr_ready_o=0, clr_busy_o=1
  - each edge zeroes entry[index] and dirty_o[index], then increments index
  - at index 15, entry 15 is cleared and state returns to IDLE with index 0
  - clr_req_i is ignored while in CLEAR; a request still high on return to IDLE starts a new sweep on the next edge
- Data is held while wr_valid_i is high and wr_ready_o is low; the requester must keep the address, data and enables stable until acceptance.
- Reset mid-sweep aborts the sweep. All entries and dirty bits go to 0 anyway.

## Timing
- Write latency: 1 cycle. Data accepted at edge n is visible on regs_o and dirty_o after edge n.
- Back-to-back writes: one per cycle at full throughput in IDLE. Two successive writes to the same entry apply in order.
- Clear sweep: clr_busy_o high for exactly 16 cycles, starting the cycle after clr_req_i is sampled. Entry i reads 0 from cycle i+1 after the sampling edge.
- Entries not yet swept still hold old data and remain readable during CLEAR.
- wr_ready_o and clr_busy_o depend only on state and clr_req_i. There is no combinational path from wr_valid_i or wr_data_i to any output.
- regs_o and dirty_o are driven directly from flops.

## Test plan
- Reset: assert rst_i mid-cycle with the bank nonzero → regs_o=0 and dirty_o=0 immediately (asynchronous); after release, wr_ready_o=1 and clr_busy_o=0.
- Full write: addr 5, data 0xDEADBEEF, be 4'hF, valid 1 cycle → entry 5 = 0xDEADBEEF and dirty_o=16'h0020 next cycle; all other entries 0.
- Partial write: entry 5 = 0xDEADBEEF, then addr 5, data 0x11223344, be 4'b0101 → entry 5 = 0xDE22BE44.
- R0: ZERO_R0=1, write addr 0, data 0xFFFFFFFF, be 4'hF → handshake completes; entry 0 stays 0 and dirty_o[0]=0.
- Clear sweep:
  - setup: write all 16 entries, then pulse clr_req_i for 1 cycle while wr_valid_i=1
  - write is not accepted in that cycle
  - clr_busy_o high for 16 cycles; entry i is 0 after sweep cycle i
  - dirty_o=0 at the end
  - the held write is accepted on the first IDLE cycle
- Reset mid-sweep: assert rst_i at sweep index 7 → state IDLE and all entries 0; a new write to addr 12 after release is accepted normally.
